// File: rtl/mdu_ctrl_if.sv
// Bus between the E-stage issue logic and the MDU sequencer (mdu_ctrl).
//
// Handshake: start is a single-cycle valid carrying op/rs_val/rt_val. The
// sequencer accepts it only when it is idle (busy == 0). A start seen while
// busy is dropped. The pipeline must not issue one, and it uses stall_req to
// hold the next MDU instruction in D until it is safe.
interface mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             d_md_use;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall_req;
  logic             state_dbg;   // FSM state: 0 idle, 1 busy

  modport master (
    output start, op, rs_val, rt_val, d_md_use,
    input  hi, lo, busy, stall_req, state_dbg
  );

  modport slave (
    input  start, op, rs_val, rt_val, d_md_use,
    output hi, lo, busy, stall_req, state_dbg
  );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU sequencer for the 5-stage MIPS pipeline. It owns HI/LO and models the
// multi-cycle latency of MULT/MULTU/DIV/DIVU with a busy counter. The result
// is computed and captured when the op starts, and it is written to HI/LO
// when the counter expires.
// Optional feature macro: MDU_MADD_EN enables MADD/MSUB, which accumulate
// into {hi,lo}. When the macro is undefined, op 6/7 are ignored.
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_ctrl_if.slave  io_mdu
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [2*WIDTH-1:0] r_res, w_res_nxt;     // {hi,lo} to commit at completion
  logic               r_skip, w_skip_nxt;   // divide by zero: commit nothing

  logic [2*WIDTH-1:0] w_sprod, w_uprod;
  logic               w_div_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_ua, w_ub, w_ub_safe, w_uq, w_ur, w_quot, w_rem;

  // Products: the operands are sign-extended (or zero-extended) to 2W, so the
  // low 2W bits hold the exact product.
  assign w_sprod = $signed({{WIDTH{io_mdu.rs_val[WIDTH-1]}}, io_mdu.rs_val}) *
                   $signed({{WIDTH{io_mdu.rt_val[WIDTH-1]}}, io_mdu.rt_val});
  assign w_uprod = {{WIDTH{1'b0}}, io_mdu.rs_val} * {{WIDTH{1'b0}}, io_mdu.rt_val};

  // One unsigned divider serves both DIV and DIVU. For signed division the
  // magnitudes are divided and the signs are fixed up afterwards. In the case
  // -2^(W-1) / -1 the magnitude quotient is 2^(W-1), so lo = 0x80..0 and
  // hi = 0 without any simulator-dependent overflow.
  assign w_div_signed = (io_mdu.op == OP_DIV);
  assign w_a_neg      = w_div_signed & io_mdu.rs_val[WIDTH-1];
  assign w_b_neg      = w_div_signed & io_mdu.rt_val[WIDTH-1];
  assign w_ua         = w_a_neg ? (-io_mdu.rs_val) : io_mdu.rs_val;
  assign w_ub         = w_b_neg ? (-io_mdu.rt_val) : io_mdu.rt_val;
  assign w_ub_safe    = (w_ub == '0) ? WIDTH'(1) : w_ub;
  assign w_uq         = w_ua / w_ub_safe;
  assign w_ur         = w_ua % w_ub_safe;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (-w_uq) : w_uq;
  assign w_rem        = w_a_neg ? (-w_ur) : w_ur;

  // State, counter, captured result and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_res   <= '0;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_res   <= w_res_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  // Next state: accept ops in IDLE, count down in BUSY, commit on the last cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_res_nxt   = r_res;
    w_skip_nxt  = r_skip;
    case (r_state)
      S_IDLE: begin
        if (io_mdu.start) begin
          case (io_mdu.op)
            OP_MULT, OP_MULTU: begin
              w_state_nxt = S_BUSY;
              w_cnt_nxt   = CW'(MULT_CYCLES);
              w_res_nxt   = (io_mdu.op == OP_MULT) ? w_sprod : w_uprod;
              w_skip_nxt  = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              w_state_nxt = S_BUSY;
              w_cnt_nxt   = CW'(DIV_CYCLES);
              w_res_nxt   = {w_rem, w_quot};
              w_skip_nxt  = (io_mdu.rt_val == '0);
            end
            OP_MTHI: w_hi_nxt = io_mdu.rs_val;
            OP_MTLO: w_lo_nxt = io_mdu.rs_val;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
              w_state_nxt = S_BUSY;
              w_cnt_nxt   = CW'(MULT_CYCLES);
              w_res_nxt   = (io_mdu.op == OP_MADD) ? ({r_hi, r_lo} + w_sprod)
                                                   : ({r_hi, r_lo} - w_sprod);
              w_skip_nxt  = 1'b0;
            end
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          if (!r_skip) begin
            w_hi_nxt = r_res[2*WIDTH-1:WIDTH];
            w_lo_nxt = r_res[WIDTH-1:0];
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stall F/D when a D-stage MDU op would meet an op in flight or one starting now
  assign io_mdu.stall_req = io_mdu.d_md_use &
                            ((r_state == S_BUSY) |
                             (io_mdu.start & ((io_mdu.op <= OP_DIVU) |
                                              (io_mdu.op == OP_MADD) |
                                              (io_mdu.op == OP_MSUB))));
  assign io_mdu.hi        = r_hi;
  assign io_mdu.lo        = r_lo;
  assign io_mdu.busy      = (r_state == S_BUSY);
  assign io_mdu.state_dbg = r_state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl. It runs directed cases with literal
// expectations and then randomized traffic. A behavioural model tracks HI/LO
// and the remaining busy cycles. A negedge process compares every output
// against that model on every cycle after reset.
module tb_mdu_ctrl;
  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  mdu_ctrl_if #(.WIDTH(W)) mif ();

  mdu_ctrl #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_mdu (mif.slave)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_left = edges still to go before the pending result lands.
  logic [W-1:0] m_hi, m_lo;
  logic [63:0]  m_res;
  logic         m_write;
  int           m_left;
  bit           m_valid = 0;
  logic [63:0]  exp_q[$];   // pending {hi,lo} result (at most one entry)

  function automatic bit is_multi(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op <= 3) || (op >= 6);
`else
    return (op <= 3);
`endif
  endfunction

  always @(posedge clk) begin
    if (mif.start && !reset) begin
      n_checks++;
      if (m_left > 0) begin
        n_errors++;
        $display("FAIL start_while_busy: got start with %0d cycles left, required idle", m_left);
      end
    end
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_write = 0; m_valid = 1;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_res = exp_q.pop_front();
        if (m_write) begin m_hi = m_res[63:32]; m_lo = m_res[31:0]; end
      end
    end else if (mif.start) begin
      longint sa, sb, q, r;
      logic [63:0] acc, prod;
      acc  = {m_hi, m_lo};
      prod = 64'(longint'($signed(mif.rs_val)) * longint'($signed(mif.rt_val)));
      m_write = 1;
      case (mif.op)
        3'd0: begin exp_q.push_back(prod); m_left = NM; end
        3'd1: begin exp_q.push_back({32'b0, mif.rs_val} * {32'b0, mif.rt_val}); m_left = NM; end
        3'd2, 3'd3: begin
          if (mif.op == 3'd2) begin
            sa = longint'($signed(mif.rs_val)); sb = longint'($signed(mif.rt_val));
          end else begin
            sa = longint'(mif.rs_val); sb = longint'(mif.rt_val);
          end
          if (sb == 0) begin m_write = 0; q = 0; r = 0; end
          else begin q = sa / sb; r = sa % sb; end
          exp_q.push_back({r[31:0], q[31:0]});
          m_left = ND;
        end
        3'd4: m_hi = mif.rs_val;
        3'd5: m_lo = mif.rs_val;
        default: begin
          if (is_multi(mif.op)) begin
            exp_q.push_back((mif.op == 3'd6) ? acc + prod : acc - prod);
            m_left = NM;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      logic exp_stall;
      exp_stall = mif.d_md_use &&
                  ((m_left > 0) || (mif.start && ((mif.op <= 3) || (mif.op >= 6))));
      chk("cyc_hi", 64'(mif.hi), 64'(m_hi));
      chk("cyc_lo", 64'(mif.lo), 64'(m_lo));
      chk("cyc_busy", 64'(mif.busy), 64'(m_left > 0));
      chk("cyc_stall", 64'(mif.stall_req), 64'(exp_stall));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; presents an op for one edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    mif.start = 1'b1; mif.op = op; mif.rs_val = a; mif.rt_val = b;
    @(posedge clk); #1;
    mif.start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (mif.busy && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, ns;
    reset = 1'b1;
    mif.start = 1'b0; mif.op = '0; mif.rs_val = '0; mif.rt_val = '0; mif.d_md_use = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 64'(mif.hi), 64'h0);
    chk("rst_lo", 64'(mif.lo), 64'h0);
    chk("rst_busy", 64'(mif.busy), 64'h0);
    chk("rst_stall", 64'(mif.stall_req), 64'h0);
    reset = 1'b0;

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    chk("mult_cycles", 64'(n), 64'd5);
    chk("mult_hi", 64'(mif.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(mif.lo), 64'hFFFF_FFFA);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("div_cycles", 64'(n), 64'd10);
    chk("div_lo", 64'(mif.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(mif.hi), 64'hFFFF_FFFF);

    // DIVU 7 / 0 leaves hi/lo alone
    issue(3'd3, 32'd7, 32'd0);
    count_busy(n);
    chk("div0_cycles", 64'(n), 64'd10);
    chk("div0_lo", 64'(mif.lo), 64'hFFFF_FFFD);
    chk("div0_hi", 64'(mif.hi), 64'hFFFF_FFFF);

    // Signed overflow
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    chk("ovf_lo", 64'(mif.lo), 64'h8000_0000);
    chk("ovf_hi", 64'(mif.hi), 64'h0);

    // MULTU with a D-stage MDU user every cycle
    mif.d_md_use = 1'b1;
    mif.start = 1'b1; mif.op = 3'd1; mif.rs_val = 32'hFFFF_FFFF; mif.rt_val = 32'hFFFF_FFFF;
    #1;
    chk("stall_at_start", 64'(mif.stall_req), 64'h1);
    @(posedge clk); #1;
    mif.start = 1'b0;
    n = 0; ns = 0;
    while (mif.busy && n < 60) begin
      n++;
      if (mif.stall_req) ns++;
      @(posedge clk); #1;
    end
    chk("multu_cycles", 64'(n), 64'd5);
    chk("multu_stall_cycles", 64'(ns), 64'd5);
    chk("stall_idle", 64'(mif.stall_req), 64'h0);
    mif.d_md_use = 1'b0;
    chk("multu_hi", 64'(mif.hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(mif.lo), 64'h1);

    // Reset aborts a divide in flight
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_before", 64'(mif.busy), 64'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(mif.busy), 64'h0);
    chk("abort_hi", 64'(mif.hi), 64'h0);
    chk("abort_lo", 64'(mif.lo), 64'h0);
    issue(3'd5, 32'h0000_1234, 32'd0);
    chk("mtlo_lo", 64'(mif.lo), 64'h1234);
    chk("mtlo_busy", 64'(mif.busy), 64'h0);

`ifdef MDU_MADD_EN
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'd10, 32'd0);
    issue(3'd6, 32'd3, 32'd4);
    count_busy(n);
    chk("madd_cycles", 64'(n), 64'd5);
    chk("madd_lo", 64'(mif.lo), 64'd22);
    chk("madd_hi", 64'(mif.hi), 64'd0);
    issue(3'd7, 32'd5, 32'd5);
    count_busy(n);
    chk("msub_cycles", 64'(n), 64'd5);
    chk("msub_lo", 64'(mif.lo), 64'hFFFF_FFFD);
    chk("msub_hi", 64'(mif.hi), 64'hFFFF_FFFF);
`else
    issue(3'd6, 32'd3, 32'd4);
    chk("madd_off_busy", 64'(mif.busy), 64'h0);
    chk("madd_off_lo", 64'(mif.lo), 64'h1234);
    issue(3'd7, 32'd5, 32'd5);
    chk("msub_off_busy", 64'(mif.busy), 64'h0);
    chk("msub_off_hi", 64'(mif.hi), 64'h0);
`endif

    // Randomized traffic, never starting while the model is busy
    for (int i = 0; i < 1500; i++) begin
      if (m_left == 0 && $urandom_range(0, 2) != 0) begin
        mif.start  = 1'b1;
        mif.op     = 3'($urandom_range(0, 7));
        mif.rs_val = rand_operand();
        mif.rt_val = rand_operand();
      end else begin
        mif.start  = 1'b0;
        mif.op     = 3'($urandom_range(0, 7));
        mif.rs_val = $urandom;
        mif.rt_val = $urandom;
      end
      mif.d_md_use = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    mif.start = 1'b0;
    reset = 1'b0;
    count_busy(n);
    chk("final_idle", 64'(mif.busy), 64'h0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
